// File: rtl/cmd_block_sequencer.sv
// Host command front end: parses header/payload words, assembles a block for the cipher
// core, waits for its done pulse (with timeout) and streams the result back word by word.
module cmd_block_sequencer #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned CFG_W       = 8,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [WORD_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          core_start,
    output logic [WORD_W*BLOCK_WORDS-1:0] core_block,
    output logic [CFG_W-1:0]              core_cfg,
    input  logic                          core_done,
    input  logic [WORD_W*BLOCK_WORDS-1:0] core_result,
    output logic                          out_valid,
    output logic [WORD_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int unsigned IDX_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_CFG  = 4'd3;

    typedef enum logic [2:0] {StIdle, StCfg, StLoad, StStart, StBusy, StDrain} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic [BLOCK_W-1:0] result_q, result_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               core_start_q, core_start_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               accept, emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        block_d  = block_q;
        result_d = result_q;
        cfg_d    = cfg_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept && in_data[WORD_W-2]) begin
                    err_d = 1'b0;
                    case (in_data[3:0])
                        OP_LOAD: begin
                            state_d = StLoad;
                            idx_d   = '0;
                        end
                        OP_CFG:  state_d = StCfg;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StCfg: begin
                if (accept) begin
                    cfg_d   = in_data[CFG_W-1:0];
                    state_d = StIdle;
                end
            end
            StLoad: begin
                // every word here is payload, the header flag is not decoded
                if (accept) begin
                    block_d[idx_q*WORD_W +: WORD_W] = in_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = StStart;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                // done takes priority over a coincident timeout
                if (core_done) begin
                    result_d = core_result;
                    idx_d    = '0;
                    state_d  = StDrain;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (emit) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d   = (state_d == StIdle) || (state_d == StCfg) || (state_d == StLoad);
        core_start_d = (state_d == StStart);
        out_valid_d  = (state_d == StDrain);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            block_q      <= '0;
            result_q     <= '0;
            cfg_q        <= '0;
            err_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            block_q      <= block_d;
            result_q     <= result_d;
            cfg_q        <= cfg_d;
            err_q        <= err_d;
            in_ready_q   <= in_ready_d;
            core_start_q <= core_start_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign core_start = core_start_q;
    assign core_block = block_q;
    assign core_cfg   = cfg_q;
    assign out_valid  = out_valid_q;
    assign out_data   = result_q[idx_q*WORD_W +: WORD_W];
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cmd_block_sequencer.sv
// Directed bench for cmd_block_sequencer: default 32x4 instance plus 16x1 and 16x8
// instances, each with a core model returning ~block ten cycles after start.
module tb_cmd_block_sequencer;

    localparam int TO = 1024;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // default instance
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready, core_start;
    logic [127:0] core_block;
    logic [7:0]   core_cfg;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready = 1'b0;
    logic         busy, err;

    // 16-bit sweep instances: index 0 -> BLOCK_WORDS=1, index 1 -> BLOCK_WORDS=8
    logic         v16 [2];
    logic [15:0]  d16 [2];
    logic         rdy16 [2];
    logic         start16 [2];
    logic         done16 [2];
    logic         ov16 [2];
    logic [15:0]  od16 [2];
    logic         ordy16 [2];
    logic [7:0]   cfg16 [2];
    logic         busy16 [2];
    logic         err16 [2];
    logic [15:0]  a_block, a_result;
    logic [127:0] b_block, b_result;

    int   n_tests = 0;
    int   n_fail = 0;
    logic core_en = 1'b1;
    int   cd_cnt = 0;
    int   cd_a = 0;
    int   cd_b = 0;
    int   start_cnt = 0;
    int   emit_cnt = 0;

    localparam logic [127:0] BLK1 = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
    localparam logic [127:0] RES1 = 128'h943e411d_d1bf6069_16c281ee_8c6ce8d5;
    localparam logic [127:0] BLK2 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] RES2 = 128'hffeeddcc_bbaa9988_77665544_33221100;

    cmd_block_sequencer dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .core_start(core_start), .core_block(core_block),
        .core_cfg(core_cfg), .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    cmd_block_sequencer #(.WORD_W(16), .BLOCK_WORDS(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .in_valid(v16[0]), .in_data(d16[0]),
        .in_ready(rdy16[0]), .core_start(start16[0]), .core_block(a_block),
        .core_cfg(cfg16[0]), .core_done(done16[0]), .core_result(a_result),
        .out_valid(ov16[0]), .out_data(od16[0]), .out_ready(ordy16[0]),
        .busy(busy16[0]), .err(err16[0])
    );

    cmd_block_sequencer #(.WORD_W(16), .BLOCK_WORDS(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .in_valid(v16[1]), .in_data(d16[1]),
        .in_ready(rdy16[1]), .core_start(start16[1]), .core_block(b_block),
        .core_cfg(cfg16[1]), .core_done(done16[1]), .core_result(b_result),
        .out_valid(ov16[1]), .out_data(od16[1]), .out_ready(ordy16[1]),
        .busy(busy16[1]), .err(err16[1])
    );

    // core models
    always @(posedge clock) begin
        core_done <= 1'b0;
        if (core_start) start_cnt <= start_cnt + 1;
        if (out_valid && out_ready) emit_cnt <= emit_cnt + 1;
        if (core_start && core_en) cd_cnt <= 10;
        else if (cd_cnt > 0) begin
            cd_cnt <= cd_cnt - 1;
            if (cd_cnt == 1) begin
                core_done   <= 1'b1;
                core_result <= ~core_block;
            end
        end
    end

    always @(posedge clock) begin
        done16[0] <= 1'b0;
        done16[1] <= 1'b0;
        if (start16[0]) cd_a <= 10;
        else if (cd_a > 0) begin
            cd_a <= cd_a - 1;
            if (cd_a == 1) begin
                done16[0] <= 1'b1;
                a_result  <= ~a_block;
            end
        end
        if (start16[1]) cd_b <= 10;
        else if (cd_b > 0) begin
            cd_b <= cd_b - 1;
            if (cd_b == 1) begin
                done16[1] <= 1'b1;
                b_result  <= ~b_block;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // all stimulus changes and samples happen on the falling edge
    task automatic push(input logic [31:0] w);
        int t;
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept: in_ready=%b required 1 for word %h", in_ready, w);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic push16(input int sel, input logic [15:0] w);
        int t;
        v16[sel] = 1'b1;
        d16[sel] = w;
        t = 0;
        while (!rdy16[sel] && t < 100) begin
            @(negedge clock);
            t++;
        end
        n_tests++;
        if (rdy16[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL push16_accept: in_ready=%b required 1 (dut %0d)", rdy16[sel], sel);
        end
        @(negedge clock);
        v16[sel] = 1'b0;
        d16[sel] = '0;
    endtask

    task automatic load_block(input logic [127:0] blk);
        push(32'h4000_0000);
        for (int k = 0; k < 4; k++) push(blk[k*32 +: 32]);
    endtask

    task automatic collect(input logic [127:0] res, input string tag);
        int t;
        int e0;
        e0 = emit_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (!out_valid && t < 200) begin
                @(negedge clock);
                t++;
            end
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== res[i*32 +: 32]) begin
                n_fail++;
                $display("FAIL %s_word%0d: valid=%b data=%h required valid=1 data=%h",
                         tag, i, out_valid, out_data, res[i*32 +: 32]);
            end
            @(negedge clock);
        end
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_end: valid=%b busy=%b in_ready=%b required 0 0 1",
                     tag, out_valid, busy, in_ready);
        end
        n_tests++;
        if (emit_cnt - e0 !== 4) begin
            n_fail++;
            $display("FAIL %s_count: emitted %0d required 4", tag, emit_cnt - e0);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (in_ready !== 1'b1 || core_start !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy=%b start=%b ov=%b busy=%b err=%b required 1 0 0 0 0",
                     in_ready, core_start, out_valid, busy, err);
        end
        n_tests++;
        if (core_block !== '0 || core_cfg !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: block=%h cfg=%h out=%h required zeros",
                     core_block, core_cfg, out_data);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_load();
        int t;
        out_ready = 1'b1;
        push(32'h4000_0000);
        for (int k = 0; k < 4; k++) push(BLK1[k*32 +: 32]);
        n_tests++;
        if (core_start !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_start_latency: start=%b rdy=%b required 1 0", core_start, in_ready);
        end
        n_tests++;
        if (core_block !== BLK1) begin
            n_fail++;
            $display("FAIL load_block: got %h required %h", core_block, BLK1);
        end
        @(negedge clock);
        n_tests++;
        if (core_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_start_pulse: start=%b busy=%b required 0 1", core_start, busy);
        end
        t = 0;
        while (!core_done && t < 50) begin
            @(negedge clock);
            t++;
        end
        n_tests++;
        if (core_done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done_seen: done=%b ov=%b required 1 0", core_done, out_valid);
        end
        @(negedge clock);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL load_done_latency: out_valid=%b required 1", out_valid);
        end
        collect(RES1, "load");
    endtask

    task automatic test_config();
        int sc;
        sc = start_cnt;
        push(32'h4000_0003);
        push(32'h0000_0094);
        n_tests++;
        if (core_cfg !== 8'h94 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL config: cfg=%h err=%b busy=%b required 94 0 0", core_cfg, err, busy);
        end
        push(32'h0000_0000);
        push(32'h0000_0000);
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || core_cfg !== 8'h94 || start_cnt !== sc) begin
            n_fail++;
            $display("FAIL config_idle_zero: busy=%b rdy=%b cfg=%h starts=%0d required 0 1 94 %0d",
                     busy, in_ready, core_cfg, start_cnt, sc);
        end
    endtask

    task automatic test_backpressure();
        int t;
        out_ready = 1'b0;
        load_block(BLK2);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clock);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== RES2[31:0] || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: ov=%b data=%h rdy=%b required 1 %h 0",
                         i, out_valid, out_data, in_ready, RES2[31:0]);
            end
            @(negedge clock);
        end
        collect(RES2, "bp");
    endtask

    task automatic test_errors();
        int t;
        push(32'h4000_0007);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_opcode: err=%b busy=%b required 1 0", err, busy);
        end
        core_en = 1'b0;
        load_block(BLK2);
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clock);
            t++;
        end
        n_tests++;
        if (t !== TO + 1) begin
            n_fail++;
            $display("FAIL err_timeout_len: busy cycles %0d required %0d", t, TO + 1);
        end
        n_tests++;
        if (err !== 1'b1 || in_ready !== 1'b1 || core_block !== BLK2) begin
            n_fail++;
            $display("FAIL err_timeout: err=%b rdy=%b block=%h required 1 1 %h",
                     err, in_ready, core_block, BLK2);
        end
        core_en = 1'b1;
        push(32'h4000_0000);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
        for (int k = 0; k < 4; k++) push(BLK1[k*32 +: 32]);
        collect(RES1, "err_recover");
    endtask

    task automatic test_reset_midload();
        push(32'h4000_0000);
        push(BLK2[31:0]);
        push(BLK2[63:32]);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || out_valid !== 1'b0 ||
            core_block !== '0 || err !== 1'b0 || core_cfg !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL midload_reset: rdy=%b busy=%b start=%b ov=%b block=%h required 1 0 0 0 0",
                     in_ready, busy, core_start, out_valid, core_block);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        load_block(BLK1);
        n_tests++;
        if (core_block !== BLK1) begin
            n_fail++;
            $display("FAIL midload_reload: block=%h required %h", core_block, BLK1);
        end
        collect(RES1, "midload");
    endtask

    task automatic test_sweep();
        int t;
        ordy16[0] = 1'b1;
        ordy16[1] = 1'b1;
        push16(0, 16'h4000);
        push16(0, 16'h1234);
        n_tests++;
        if (a_block !== 16'h1234 || start16[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep1_load: block=%h start=%b required 1234 1", a_block, start16[0]);
        end
        t = 0;
        while (!ov16[0] && t < 50) begin
            @(negedge clock);
            t++;
        end
        n_tests++;
        if (ov16[0] !== 1'b1 || od16[0] !== 16'hedcb) begin
            n_fail++;
            $display("FAIL sweep1_out: ov=%b data=%h required 1 edcb", ov16[0], od16[0]);
        end
        @(negedge clock);
        n_tests++;
        if (ov16[0] !== 1'b0 || busy16[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep1_end: ov=%b busy=%b required 0 0", ov16[0], busy16[0]);
        end

        push16(1, 16'h4000);
        for (int k = 0; k < 8; k++) push16(1, 16'ha000 + 16'(k));
        n_tests++;
        if (b_block !== 128'ha007_a006_a005_a004_a003_a002_a001_a000) begin
            n_fail++;
            $display("FAIL sweep8_load: block=%h required a007..a000", b_block);
        end
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (!ov16[1] && t < 50) begin
                @(negedge clock);
                t++;
            end
            n_tests++;
            if (ov16[1] !== 1'b1 || od16[1] !== 16'h5fff - 16'(k)) begin
                n_fail++;
                $display("FAIL sweep8_word%0d: ov=%b data=%h required 1 %h",
                         k, ov16[1], od16[1], 16'h5fff - 16'(k));
            end
            @(negedge clock);
        end
        n_tests++;
        if (ov16[1] !== 1'b0 || busy16[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep8_end: ov=%b busy=%b required 0 0", ov16[1], busy16[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            v16[i]    = 1'b0;
            d16[i]    = '0;
            ordy16[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        test_reset();
        test_load();
        test_config();
        test_backpressure();
        test_errors();
        test_reset_midload();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
